// File: rtl/ipg_pkg.sv
// Shared definitions for the IPG chunk scheduler.
// Contents:
//   - sync header codes for the 64b/66b stream
//   - block type codes for control, terminate and IPG-chunk blocks
//   - scheduler FSM state type
//   - is_ipg_slot(): decides whether a monitored block opens an IPG slot
package ipg_pkg;

  localparam logic [1:0] SYNC_DATA = 2'b10;
  localparam logic [1:0] SYNC_CTRL = 2'b01;

  localparam logic [7:0] BLOCK_TYPE_CTRL   = 8'h1e;
  localparam logic [7:0] BLOCK_TYPE_TERM_0 = 8'h87;
  localparam logic [7:0] BLOCK_TYPE_TERM_1 = 8'h99;
  localparam logic [7:0] BLOCK_TYPE_TERM_2 = 8'haa;
  localparam logic [7:0] BLOCK_TYPE_TERM_3 = 8'hb4;
  localparam logic [7:0] BLOCK_TYPE_TERM_4 = 8'hcc;
  localparam logic [7:0] BLOCK_TYPE_TERM_5 = 8'hd2;
  localparam logic [7:0] BLOCK_TYPE_TERM_6 = 8'he1;
  localparam logic [7:0] BLOCK_TYPE_TERM_7 = 8'hff;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } ipg_state_e;

  // A slot is a control block that is either a terminate or an all-control
  // block. The header compare sits in an if so an unknown header is treated
  // as "not a slot" rather than propagating X into the grant logic.
  function automatic logic is_ipg_slot(input logic [1:0] hdr, input logic [7:0] btype);
    logic ok;
    ok = 1'b0;
    if (hdr == SYNC_CTRL) begin
      case (btype)
        BLOCK_TYPE_CTRL,
        BLOCK_TYPE_TERM_0, BLOCK_TYPE_TERM_1, BLOCK_TYPE_TERM_2, BLOCK_TYPE_TERM_3,
        BLOCK_TYPE_TERM_4, BLOCK_TYPE_TERM_5, BLOCK_TYPE_TERM_6, BLOCK_TYPE_TERM_7:
          ok = 1'b1;
        default:
          ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

endpackage

// File: rtl/ipg_rr_arbiter.sv
// Combinational round-robin arbiter.
// Picks the first set bit of req_i at or after ptr_i, wrapping modulo N.
// Ports:
//   req_i      in  N   request mask
//   ptr_i      in  IW  index with highest priority this cycle
//   gnt_o      out N   one-hot grant (zero when no request)
//   gnt_idx_o  out IW  index of the granted request
//   gnt_vld_o  out 1   at least one request was present
module ipg_rr_arbiter #(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] gnt_idx_o,
  output logic          gnt_vld_o
);

  function automatic logic [IW-1:0] rot(input logic [IW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= N) s = s - N;
    return IW'(s);
  endfunction

  // Scan from the farthest offset back to ptr_i so the nearest request wins.
  always_comb begin
    gnt_idx_o = '0;
    gnt_vld_o = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req_i[rot(ptr_i, k)]) begin
        gnt_idx_o = rot(ptr_i, k);
        gnt_vld_o = 1'b1;
      end
    end
  end

  assign gnt_o = gnt_vld_o ? (N'(1) << gnt_idx_o) : '0;

endmodule

// File: rtl/ipg_chunk_sched.sv
// IPG chunk scheduler.
// Watches the encoded TX stream for inter-packet-gap slots and fills each
// slot with one 56-bit chunk from one of N_REQ requesters, formatted as an
// all-control (0x1e) block. Requesters are picked round-robin; once a
// requester starts a multi-chunk message it owns every slot until it sends
// its last chunk or hits MAX_MSG_CHUNKS, in which case msg_abort pulses.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   encoded_tx_hdr    sync header of the monitored block
//   encoded_tx_data   monitored block, [7:0] = block type
//   req_valid/data/last  per-requester chunk offer (data 56 bits each)
//   req_ready         one-hot combinational accept
//   ipg_reply_chunk   registered {payload, 8'h1e}
//   ipg_reply_valid   chunk register loaded in the previous cycle
//   ipg_reply_src     requester index of the chunk
//   msg_abort         one-cycle pulse on forced release
module ipg_chunk_sched
  import ipg_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int MAX_MSG_CHUNKS = 16,
  parameter int CNT_W          = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          encoded_tx_hdr,
  input  logic [63:0]         encoded_tx_data,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [56*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]    req_last,
  output logic [N_REQ-1:0]    req_ready,
  output logic [63:0]         ipg_reply_chunk,
  output logic                ipg_reply_valid,
  output logic [2:0]          ipg_reply_src,
  output logic                msg_abort
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  ipg_state_e        state_q, state_d;
  logic [PW-1:0]     owner_q, owner_d;
  logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [63:0]       chunk_q, chunk_d;
  logic              vld_q, vld_d;
  logic [2:0]        src_q, src_d;
  logic              abort_q, abort_d;

  logic              slot;
  logic [N_REQ-1:0]  arb_gnt;
  logic [PW-1:0]     arb_idx;
  logic              arb_vld;
  logic [N_REQ-1:0]  win_onehot;
  logic [PW-1:0]     win_idx;
  logic              win_vld;
  logic              win_last;
  logic [55:0]       win_data;
  logic              hs;
  logic              unused_tx_bits;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(N_REQ - 1)) ? '0 : p + PW'(1);
  endfunction

  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] c);
    if (c >= CNT_W'(MAX_MSG_CHUNKS)) return CNT_W'(MAX_MSG_CHUNKS);
    return c + CNT_W'(1);
  endfunction

  assign slot           = is_ipg_slot(encoded_tx_hdr, encoded_tx_data[7:0]);
  assign unused_tx_bits = ^encoded_tx_data[63:8];

  ipg_rr_arbiter #(.N(N_REQ)) u_arb (
    .req_i     (req_valid),
    .ptr_i     (rr_ptr_q),
    .gnt_o     (arb_gnt),
    .gnt_idx_o (arb_idx),
    .gnt_vld_o (arb_vld)
  );

  // While locked only the owner may be served; an idle owner wastes the slot.
  always_comb begin
    if (state_q == LOCKED) begin
      win_idx    = owner_q;
      win_vld    = req_valid[owner_q];
      win_onehot = N_REQ'(1) << owner_q;
    end else begin
      win_idx    = arb_idx;
      win_vld    = arb_vld;
      win_onehot = arb_gnt;
    end
  end

  always_comb begin
    win_data = '0;
    win_last = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_idx == PW'(i)) begin
        win_data = req_data[56*i +: 56];
        win_last = req_last[i];
      end
    end
  end

  // Gating with rst keeps ready low for the whole reset assertion, not just
  // until the registers clear.
  assign hs        = slot && win_vld && !rst;
  assign req_ready = hs ? win_onehot : '0;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    chunk_d  = chunk_q;
    vld_d    = 1'b0;
    src_d    = src_q;
    abort_d  = 1'b0;
    if (hs) begin
      chunk_d = {win_data, BLOCK_TYPE_CTRL};
      vld_d   = 1'b1;
      src_d   = 3'(win_idx);
      if (state_q == IDLE) begin
        if (win_last) begin
          rr_ptr_d = ptr_inc(win_idx);
        end else begin
          state_d = LOCKED;
          owner_d = win_idx;
          cnt_d   = CNT_W'(1);
        end
      end else begin
        cnt_d = cnt_sat_inc(cnt_q);
        if (win_last) begin
          state_d  = IDLE;
          rr_ptr_d = ptr_inc(owner_q);
          cnt_d    = '0;
        end else if (cnt_sat_inc(cnt_q) == CNT_W'(MAX_MSG_CHUNKS)) begin
          state_d  = IDLE;
          rr_ptr_d = ptr_inc(owner_q);
          cnt_d    = '0;
          abort_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
      chunk_q  <= '0;
      vld_q    <= 1'b0;
      src_q    <= '0;
      abort_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
      chunk_q  <= chunk_d;
      vld_q    <= vld_d;
      src_q    <= src_d;
      abort_q  <= abort_d;
    end
  end

  assign ipg_reply_chunk = chunk_q;
  assign ipg_reply_valid = vld_q;
  assign ipg_reply_src   = src_q;
  assign msg_abort       = abort_q;

endmodule

// File: tb/tb_ipg_chunk_sched.sv
module tb_ipg_chunk_sched;

  localparam int N    = 4;
  localparam int MAXC = 4;

  logic           clk;
  logic           rst;
  logic [1:0]     hdr;
  logic [63:0]    txd;
  logic [N-1:0]   req_valid;
  logic [56*N-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic [63:0]    ipg_reply_chunk;
  logic           ipg_reply_valid;
  logic [2:0]     ipg_reply_src;
  logic           msg_abort;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  bit          m_locked;
  int          m_owner;
  int          m_rr;
  int          m_cnt;
  logic [63:0] e_chunk;
  logic        e_vld;
  logic [2:0]  e_src;
  logic        e_abort;
  logic [N-1:0] e_ready;
  logic [N-1:0] o_ready;

  ipg_chunk_sched #(.N_REQ(N), .MAX_MSG_CHUNKS(MAXC), .CNT_W(3)) dut (
    .clk             (clk),
    .rst             (rst),
    .encoded_tx_hdr  (hdr),
    .encoded_tx_data (txd),
    .req_valid       (req_valid),
    .req_data        (req_data),
    .req_last        (req_last),
    .req_ready       (req_ready),
    .ipg_reply_chunk (ipg_reply_chunk),
    .ipg_reply_valid (ipg_reply_valid),
    .ipg_reply_src   (ipg_reply_src),
    .msg_abort       (msg_abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_locked = 0; m_owner = 0; m_rr = 0; m_cnt = 0;
    e_chunk = '0; e_vld = 0; e_src = '0; e_abort = 0;
  endtask

  task automatic rand_payload();
    for (int i = 0; i < N; i++) req_data[56*i +: 56] = 56'({$urandom, $urandom});
  endtask

  task automatic set_block(input logic [1:0] h, input logic [7:0] t);
    hdr = h;
    txd = {56'({$urandom, $urandom}), t};
  endtask

  // Advance one clock: predict ready from the current inputs, capture the
  // DUT's ready, clock, then update the model's expected registered outputs.
  task automatic cyc();
    bit          slot;
    int          cand;
    logic [55:0] pay;
    logic        lst;
    #2;
    slot = (hdr === 2'b01) &&
           (txd[7:0] inside {8'h1e, 8'h87, 8'h99, 8'haa, 8'hb4, 8'hcc, 8'hd2, 8'he1, 8'hff});
    cand = -1;
    if (m_locked) begin
      if (req_valid[m_owner]) cand = m_owner;
    end else begin
      for (int k = 0; k < N; k++)
        if (cand < 0 && req_valid[(m_rr + k) % N]) cand = (m_rr + k) % N;
    end
    e_ready = (slot && cand >= 0) ? N'(1 << cand) : '0;
    pay = (cand >= 0) ? req_data[cand*56 +: 56] : '0;
    lst = (cand >= 0) ? req_last[cand] : 1'b0;
    o_ready = req_ready;
    @(posedge clk);
    #1;
    e_abort = 0;
    if (slot && cand >= 0) begin
      e_chunk = {pay, 8'h1e};
      e_vld   = 1;
      e_src   = 3'(cand);
      if (!m_locked) begin
        if (lst) m_rr = (cand + 1) % N;
        else begin m_locked = 1; m_owner = cand; m_cnt = 1; end
      end else begin
        m_cnt++;
        if (lst) begin
          m_locked = 0; m_rr = (m_owner + 1) % N; m_cnt = 0;
        end else if (m_cnt >= MAXC) begin
          m_locked = 0; m_rr = (m_owner + 1) % N; m_cnt = 0; e_abort = 1;
        end
      end
    end else begin
      e_vld = 0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    model_reset();
    rst = 1'b1;
    set_block(2'b01, 8'h1e);
    req_valid = '1; req_last = '1; rand_payload();
    #2;
    n_vec++;
    if (req_ready !== '0) begin
      n_err++; $display("FAIL reset_ready got %b want 0000", req_ready);
    end
    @(posedge clk);
    #1;
    n_vec++;
    if ({ipg_reply_chunk, ipg_reply_valid, ipg_reply_src, msg_abort} !== 69'd0) begin
      n_err++;
      $display("FAIL reset_outputs got chunk=%h v=%b src=%0d abort=%b want all 0",
               ipg_reply_chunk, ipg_reply_valid, ipg_reply_src, msg_abort);
    end
    rst = 1'b0;
  endtask

  task automatic test_single_chunk();
    do_reset();
    set_block(2'b01, 8'h99);
    req_valid = 4'b0001; req_last = 4'b1111; rand_payload();
    req_data[55:0] = 56'hccccaaaaccccaa;
    cyc();
    n_vec++;
    if (o_ready !== 4'b0001 || o_ready !== e_ready) begin
      n_err++; $display("FAIL single_ready got %b want 0001", o_ready);
    end
    n_vec++;
    if (ipg_reply_chunk !== 64'hccccaaaaccccaa1e || ipg_reply_valid !== 1'b1 || ipg_reply_src !== 3'd0) begin
      n_err++;
      $display("FAIL single_reply got chunk=%h v=%b src=%0d want ccccaaaaccccaa1e 1 0",
               ipg_reply_chunk, ipg_reply_valid, ipg_reply_src);
    end
    // Pointer has moved to 1: with everyone valid, requester 1 wins.
    req_valid = 4'b1111;
    cyc();
    n_vec++;
    if (o_ready !== 4'b0010) begin
      n_err++; $display("FAIL single_rrptr got %b want 0010", o_ready);
    end
  endtask

  task automatic test_not_slot();
    logic [1:0] hdrs [3] = '{2'b10, 2'b01, 2'bxx};
    logic [7:0] typs [3] = '{8'h77, 8'h78, 8'h1e};
    do_reset();
    req_valid = 4'b1111; req_last = 4'b1111;
    for (int s = 0; s < 3; s++) begin
      rand_payload();
      if (s == 0) begin hdr = 2'b10; txd = 64'hbb11223344556677; end
      else set_block(hdrs[s], typs[s]);
      cyc();
      n_vec++;
      if (o_ready !== 4'b0000) begin
        n_err++; $display("FAIL not_slot_ready[%0d] got %b want 0000", s, o_ready);
      end
      n_vec++;
      if (ipg_reply_valid !== 1'b0) begin
        n_err++; $display("FAIL not_slot_valid[%0d] got %b want 0", s, ipg_reply_valid);
      end
    end
  endtask

  task automatic test_rr_fair();
    int want [4] = '{0, 2, 0, 2};
    do_reset();
    req_valid = 4'b0101; req_last = 4'b1111;
    for (int s = 0; s < 4; s++) begin
      set_block(2'b01, (s % 2) ? 8'h1e : 8'hff);
      rand_payload();
      cyc();
      n_vec++;
      if (o_ready !== N'(1 << want[s]) || o_ready !== e_ready) begin
        n_err++; $display("FAIL rr_ready[%0d] got %b want %b", s, o_ready, N'(1 << want[s]));
      end
      n_vec++;
      if (ipg_reply_src !== 3'(want[s]) || ipg_reply_valid !== 1'b1 || ipg_reply_chunk !== e_chunk) begin
        n_err++; $display("FAIL rr_src[%0d] got src=%0d v=%b want src=%0d v=1",
                          s, ipg_reply_src, ipg_reply_valid, want[s]);
      end
    end
  endtask

  task automatic test_lock();
    logic [3:0] vld  [5] = '{4'b1010, 4'b1010, 4'b1000, 4'b1010, 4'b1010};
    logic [3:0] lst  [5] = '{4'b1000, 4'b1000, 4'b1000, 4'b1010, 4'b1010};
    logic [3:0] want [5] = '{4'b0010, 4'b0010, 4'b0000, 4'b0010, 4'b1000};
    do_reset();
    for (int s = 0; s < 5; s++) begin
      set_block(2'b01, 8'hd2);
      req_valid = vld[s]; req_last = lst[s]; rand_payload();
      cyc();
      n_vec++;
      if (o_ready !== want[s] || o_ready !== e_ready) begin
        n_err++; $display("FAIL lock_ready[%0d] got %b want %b", s, o_ready, want[s]);
      end
      n_vec++;
      if ({ipg_reply_chunk, ipg_reply_valid, ipg_reply_src, msg_abort} !== {e_chunk, e_vld, e_src, e_abort}
          || ipg_reply_valid !== (want[s] != 0)) begin
        n_err++; $display("FAIL lock_reply[%0d] got v=%b src=%0d want v=%b src=%0d",
                          s, ipg_reply_valid, ipg_reply_src, e_vld, e_src);
      end
    end
  endtask

  task automatic test_forced_release();
    logic [3:0] want  [5] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010};
    logic       abrt  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    do_reset();
    req_valid = 4'b0011; req_last = 4'b0000;
    for (int s = 0; s < 5; s++) begin
      set_block(2'b01, 8'h87);
      rand_payload();
      cyc();
      n_vec++;
      if (o_ready !== want[s] || o_ready !== e_ready) begin
        n_err++; $display("FAIL abort_ready[%0d] got %b want %b", s, o_ready, want[s]);
      end
      n_vec++;
      if (msg_abort !== abrt[s] || msg_abort !== e_abort || ipg_reply_chunk !== e_chunk) begin
        n_err++; $display("FAIL abort_pulse[%0d] got %b want %b", s, msg_abort, abrt[s]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] typs [6] = '{8'h1e, 8'h87, 8'haa, 8'hb4, 8'hcc, 8'he1};
    do_reset();
    req_valid = 4'b1111; req_last = 4'b1111;
    for (int s = 0; s < 6; s++) begin
      set_block(2'b01, typs[s]);
      rand_payload();
      cyc();
      n_vec++;
      if (o_ready !== N'(1 << (s % N))) begin
        n_err++; $display("FAIL b2b_ready[%0d] got %b want %b", s, o_ready, N'(1 << (s % N)));
      end
      n_vec++;
      if (ipg_reply_valid !== 1'b1 || ipg_reply_chunk !== e_chunk || ipg_reply_src !== 3'(s % N)) begin
        n_err++; $display("FAIL b2b_reply[%0d] got v=%b src=%0d chunk=%h want v=1 src=%0d chunk=%h",
                          s, ipg_reply_valid, ipg_reply_src, ipg_reply_chunk, s % N, e_chunk);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_block(2'b01, 8'h1e);
    req_valid = 4'b0100; req_last = 4'b0000; rand_payload();
    cyc();
    cyc();
    #2;
    rst = 1'b1;
    #1;
    n_vec++;
    if ({ipg_reply_chunk, ipg_reply_valid, ipg_reply_src, msg_abort} !== 69'd0 || req_ready !== '0) begin
      n_err++; $display("FAIL rstmid_outputs got chunk=%h v=%b src=%0d abort=%b ready=%b want all 0",
                        ipg_reply_chunk, ipg_reply_valid, ipg_reply_src, msg_abort, req_ready);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    req_valid = 4'b0110; req_last = 4'b1111;
    cyc();
    n_vec++;
    if (o_ready !== 4'b0010) begin
      n_err++; $display("FAIL rstmid_first_grant got %b want 0010", o_ready);
    end
  endtask

  task automatic test_random();
    logic [7:0] typs [12] = '{8'h1e, 8'h87, 8'h99, 8'haa, 8'hb4, 8'hcc, 8'hd2, 8'he1, 8'hff,
                              8'h78, 8'h33, 8'h4b};
    int r;
    do_reset();
    for (int s = 0; s < 1500; s++) begin
      r = $urandom_range(0, 9);
      hdr = (r < 7) ? 2'b01 : (r == 7) ? 2'b10 : (r == 8) ? 2'b00 : 2'b11;
      txd = {56'({$urandom, $urandom}), typs[$urandom_range(0, 11)]};
      req_valid = N'($urandom);
      for (int i = 0; i < N; i++) req_last[i] = ($urandom_range(0, 3) == 0);
      rand_payload();
      cyc();
      n_vec++;
      if (o_ready !== e_ready) begin
        n_err++; $display("FAIL rand_ready[%0d] got %b want %b", s, o_ready, e_ready);
      end
      n_vec++;
      if ({ipg_reply_chunk, ipg_reply_valid, ipg_reply_src, msg_abort} !== {e_chunk, e_vld, e_src, e_abort}) begin
        n_err++; $display("FAIL rand_reply[%0d] got %h/%b/%0d/%b want %h/%b/%0d/%b", s,
                          ipg_reply_chunk, ipg_reply_valid, ipg_reply_src, msg_abort,
                          e_chunk, e_vld, e_src, e_abort);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    hdr = 2'b00; txd = '0; req_valid = '0; req_data = '0; req_last = '0;
    test_reset();
    test_single_chunk();
    test_not_slot();
    test_rr_fair();
    test_lock();
    test_forced_release();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
